// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial evaluator/inverse: FSM states, ALU operand selects and ops.
package poly_pkg;

    typedef enum logic [4:0] {
        S_LOAD_A,
        S_LOAD_A_WAIT,
        S_LOAD_B,
        S_LOAD_B_WAIT,
        S_LOAD_C,
        S_LOAD_C_WAIT,
        S_LOAD_Y,
        S_LOAD_Y_WAIT,
        S_INIT,
        S_MUL_BX,
        S_ADD_A,
        S_MUL_XX,
        S_MUL_CU,
        S_CMP,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {R_A, R_B, R_C, R_X, R_Y, R_T, R_U} alu_sel_t;

    typedef enum logic {ALU_ADD, ALU_MUL} alu_op_t;

    function automatic logic is_search(input state_t s);
        return (s == S_MUL_BX) || (s == S_ADD_A) || (s == S_MUL_XX) ||
               (s == S_MUL_CU) || (s == S_CMP);
    endfunction

endpackage

// File: rtl/poly_alu.sv
// Shared combinational ALU: selects two datapath registers and adds or multiplies them,
// keeping the low WIDTH bits.
module poly_alu
    import poly_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] u,
    input  alu_sel_t         sel_l,
    input  alu_sel_t         sel_r,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] opnd_l;
    logic [WIDTH-1:0] opnd_r;

    always_comb begin
        opnd_l = '0;
        unique case (sel_l)
            R_A:     opnd_l = a;
            R_B:     opnd_l = b;
            R_C:     opnd_l = c;
            R_X:     opnd_l = x;
            R_Y:     opnd_l = y;
            R_T:     opnd_l = t;
            R_U:     opnd_l = u;
            default: opnd_l = '0;
        endcase
    end

    always_comb begin
        opnd_r = '0;
        unique case (sel_r)
            R_A:     opnd_r = a;
            R_B:     opnd_r = b;
            R_C:     opnd_r = c;
            R_X:     opnd_r = x;
            R_Y:     opnd_r = y;
            R_T:     opnd_r = t;
            R_U:     opnd_r = u;
            default: opnd_r = '0;
        endcase
    end

    // Both results are evaluated at WIDTH bits, i.e. modulo 2^WIDTH.
    always_comb begin
        result = '0;
        if (op == ALU_MUL) begin
            result = opnd_l * opnd_r;
        end else begin
            result = opnd_l + opnd_r;
        end
    end

endmodule

// File: rtl/poly_inverse.sv
// Finds the smallest x with A + B*x + C*x*x == Y (mod 2^WIDTH) by exhaustive search,
// five cycles per candidate through one shared ALU.
module poly_inverse
    import poly_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] x_result,
    output logic             found,
    output logic             done,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, c_q, y_q, x_q, t_q, u_q;
    logic [WIDTH-1:0] alu_res;
    alu_sel_t         sel_l, sel_r;
    alu_op_t          op;
    logic             match;

    poly_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .c      (c_q),
        .x      (x_q),
        .y      (y_q),
        .t      (t_q),
        .u      (u_q),
        .sel_l  (sel_l),
        .sel_r  (sel_r),
        .op     (op),
        .result (alu_res)
    );

    always_comb begin
        state_d = state_q;
        sel_l   = R_B;
        sel_r   = R_X;
        op      = ALU_MUL;
        match   = 1'b0;
        unique case (state_q)
            S_LOAD_A:      if (go)  state_d = S_LOAD_A_WAIT;
            S_LOAD_A_WAIT: if (!go) state_d = S_LOAD_B;
            S_LOAD_B:      if (go)  state_d = S_LOAD_B_WAIT;
            S_LOAD_B_WAIT: if (!go) state_d = S_LOAD_C;
            S_LOAD_C:      if (go)  state_d = S_LOAD_C_WAIT;
            S_LOAD_C_WAIT: if (!go) state_d = S_LOAD_Y;
            S_LOAD_Y:      if (go)  state_d = S_LOAD_Y_WAIT;
            S_LOAD_Y_WAIT: if (!go) state_d = S_INIT;
            S_INIT:        state_d = S_MUL_BX;
            S_MUL_BX: begin
                sel_l = R_B; sel_r = R_X; op = ALU_MUL;
                state_d = S_ADD_A;
            end
            S_ADD_A: begin
                sel_l = R_T; sel_r = R_A; op = ALU_ADD;
                state_d = S_MUL_XX;
            end
            S_MUL_XX: begin
                sel_l = R_X; sel_r = R_X; op = ALU_MUL;
                state_d = S_MUL_CU;
            end
            S_MUL_CU: begin
                sel_l = R_C; sel_r = R_U; op = ALU_MUL;
                state_d = S_CMP;
            end
            S_CMP: begin
                sel_l = R_T; sel_r = R_U; op = ALU_ADD;
                match = (alu_res == y_q);
                state_d = (match || (x_q == '1)) ? S_DONE : S_MUL_BX;
            end
            S_DONE:  state_d = S_LOAD_A;
            default: state_d = S_LOAD_A;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            y_q      <= '0;
            x_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            x_result <= '0;
            found    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= is_search(state_d);
            unique case (state_q)
                S_LOAD_A:           a_q <= data_in;
                S_LOAD_B:           b_q <= data_in;
                S_LOAD_C:           c_q <= data_in;
                S_LOAD_Y:           y_q <= data_in;
                S_INIT:             x_q <= '0;
                S_MUL_BX, S_ADD_A:  t_q <= alu_res;
                S_MUL_XX, S_MUL_CU: u_q <= alu_res;
                S_CMP: begin
                    // Terminal check comes before the increment, so x never wraps.
                    if (match) begin
                        x_result <= x_q;
                        found    <= 1'b1;
                        done     <= 1'b1;
                    end else if (x_q == '1) begin
                        x_result <= '0;
                        found    <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        x_q <= x_q + WIDTH'(1);
                    end
                end
                S_DONE:  done <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
